// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative multiply/divide sequencer.
package md_pkg;

   typedef enum logic [1:0] {
      MD_MUL  = 2'b00,
      MD_DIVU = 2'b01,
      MD_REMU = 2'b10,
      MD_RSVD = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam int         ITER_CNT = 32;

endpackage

// File: rtl/mul_div_sequencer.sv
// Shift-add multiply / restoring divide using an external shared ALU, one bit per cycle.
// 32 ITER cycles then a one-cycle DONE pulse; divide-by-zero and reserved op finish in one cycle.
module mul_div_sequencer
   import md_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic [1:0]  i_md_op,
   input  logic [31:0] i_operand_a,
   input  logic [31:0] i_operand_b,
   input  logic        i_flush,
   input  logic [31:0] i_alu_data,
   output logic        o_alu_req,
   output logic [31:0] o_alu_a,
   output logic [31:0] o_alu_b,
   output logic [3:0]  o_alu_op,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_result,
   output logic        o_err
);

   md_state_e   state_q, state_d;
   md_op_e      op_q, op_d, start_op;
   logic [31:0] acc_q, acc_d;        // MUL accumulator, or DIV remainder
   logic [31:0] mcand_q, mcand_d;    // MUL multiplicand, or DIV dividend
   logic [31:0] mplier_q, mplier_d;  // MUL multiplier, or DIV divisor
   logic [31:0] quot_q, quot_d;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] partial;
   logic        part_ge;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         op_q     <= MD_MUL;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         quot_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         quot_q   <= quot_d;
         result_q <= result_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   // The compare keeps the bit shifted out of rem[31] so divisors above 2^31 still divide correctly.
   assign partial = {acc_q[30:0], mcand_q[31]};
   assign part_ge = ({acc_q, mcand_q[31]} >= {1'b0, mplier_q});

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      quot_d    = quot_q;
      result_d  = result_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      o_alu_req = 1'b0;
      o_alu_a   = '0;
      o_alu_b   = '0;
      o_alu_op  = ALU_ADD;
      start_op  = md_op_e'(i_md_op);

      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_flush) begin
               op_d     = start_op;
               acc_d    = '0;
               mcand_d  = i_operand_a;
               mplier_d = i_operand_b;
               quot_d   = '0;
               cnt_d    = '0;
               err_d    = 1'b0;
               if (start_op == MD_RSVD) begin
                  result_d = '0;
                  err_d    = 1'b1;
                  state_d  = ST_DONE;
               end else if (start_op != MD_MUL && i_operand_b == 32'd0) begin
                  result_d = (start_op == MD_DIVU) ? 32'hFFFF_FFFF : i_operand_a;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_ITER;
               end
            end
         end

         ST_ITER: begin
            o_alu_req = 1'b1;
            if (op_q == MD_MUL) begin
               if (mplier_q[0]) begin
                  o_alu_a = acc_q;
                  o_alu_b = mcand_q;
                  acc_d   = i_alu_data;
               end
               mcand_d  = {mcand_q[30:0], 1'b0};
               mplier_d = {1'b0, mplier_q[31:1]};
            end else begin
               o_alu_op = ALU_SUB;
               o_alu_a  = partial;
               o_alu_b  = mplier_q;
               if (part_ge) begin
                  acc_d  = i_alu_data;
                  quot_d = {quot_q[30:0], 1'b1};
               end else begin
                  acc_d  = partial;
                  quot_d = {quot_q[30:0], 1'b0};
               end
               mcand_d = {mcand_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(ITER_CNT - 1)) begin
               state_d  = ST_DONE;
               result_d = (op_q == MD_DIVU) ? quot_d : acc_d;
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase

      if (i_flush && state_q != ST_IDLE) begin
         state_d  = ST_IDLE;
         result_d = result_q;
         err_d    = err_q;
      end
   end

   assign o_busy   = (state_q != ST_IDLE);
   assign o_done   = (state_q == ST_DONE);
   assign o_result = result_q;
   assign o_err    = err_q && (state_q == ST_DONE);

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Randomized and directed bench for mul_div_sequencer with a scoreboard-driven completion monitor.
module tb_mul_div_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  md_op = 2'd0;
   logic [31:0] opa = '0;
   logic [31:0] opb = '0;
   logic [31:0] alu_data;
   logic        alu_req;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic        busy, done, err;
   logic [31:0] result;

   int          total = 0;
   int          bad = 0;
   logic [32:0] sb[$];
   logic [32:0] mon_exp;
   logic [31:0] last_res = '0;

   mul_div_sequencer dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_md_op     (md_op),
      .i_operand_a (opa),
      .i_operand_b (opb),
      .i_flush     (flush),
      .i_alu_data  (alu_data),
      .o_alu_req   (alu_req),
      .o_alu_a     (alu_a),
      .o_alu_b     (alu_b),
      .o_alu_op    (alu_op),
      .o_busy      (busy),
      .o_done      (done),
      .o_result    (result),
      .o_err       (err)
   );

   always #5 clk = ~clk;

   // The shared ALU: combinational add/sub.
   assign alu_data = !alu_req ? 32'd0 : ((alu_op == 4'b0001) ? alu_a - alu_b : alu_a + alu_b);

   function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] p;
      case (op)
         2'd0: begin p = a * b; return {1'b0, p}; end
         2'd1: return (b == 32'd0) ? {1'b0, 32'hFFFF_FFFF} : {1'b0, a / b};
         2'd2: return (b == 32'd0) ? {1'b0, a} : {1'b0, a % b};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   function automatic int latency(input logic [1:0] op, input logic [31:0] b);
      return (op == 2'd3 || (op != 2'd0 && b == 32'd0)) ? 1 : 33;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got completion with result %0h want none", result);
         end else begin
            mon_exp = sb.pop_front();
            check("result_err", 128'({err, result}), 128'(mon_exp));
            last_res = mon_exp[31:0];
         end
      end
   end

   // Returns at the negedge of cycle T+1.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      opa   = a;
      opb   = b;
      if (push) sb.push_back(model(op, a, b));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int exp_lat, input string name, input int k0);
      int k;
      bit busy_ok;
      k = k0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && k < 45) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         md_op = 2'($urandom_range(0, 3));
         opa   = $urandom;
         opb   = $urandom;
         @(negedge clk);
         k++;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      check({name, "_latency"}, 128'(k), 128'(exp_lat));
      check({name, "_busy"}, 128'(busy_ok), 128'(1));
      @(negedge clk);
      check({name, "_idle_after"}, 128'({busy, done, alu_req}), 128'(0));
   endtask

   logic [1:0]  d_op[7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
   logic [31:0] d_a[7]  = '{32'd7, 32'd100, 32'd100, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd9};
   logic [31:0] d_b[7]  = '{32'd6, 32'd7, 32'd7, 32'd2, 32'd0, 32'd0, 32'd3};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish before timeout");
      $fatal(1);
   end

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      repeat (2) @(negedge clk);
      check("reset_outputs", 128'({busy, done, err, alu_req, result, alu_a, alu_b, alu_op}), 128'(0));
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         issue(d_op[i], d_a[i], d_b[i], 1'b1);
         wait_done(latency(d_op[i], d_b[i]), "directed", 1);
      end

      // Flush a MUL at T+10.
      issue(2'd0, 32'd3, 32'd5, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", 128'(busy), 128'(0));
      check("flush_result", 128'(result), 128'(last_res));
      repeat (40) @(negedge clk);

      // Start pulsed during ITER with new operands must be ignored.
      issue(2'd0, 32'd7, 32'd6, 1'b1);
      repeat (5) @(negedge clk);
      start = 1'b1;
      md_op = 2'd1;
      opa   = 32'd100;
      opb   = 32'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done(33, "ignore_start", 7);

      // Reset at T+20 of a DIVU, then a fresh DIVU.
      issue(2'd1, 32'd100, 32'd7, 1'b0);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midop_reset", 128'({busy, done, err, alu_req, result, alu_a, alu_b, alu_op}), 128'(0));
      last_res = '0;
      issue(2'd1, 32'd100, 32'd7, 1'b1);
      wait_done(33, "after_reset", 1);

      for (int i = 0; i < 30; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         if ($urandom_range(0, 5) == 0)      r_b = 32'd0;
         else if ($urandom_range(0, 1) == 1) r_b = $urandom;
         else                                r_b = 32'($urandom_range(1, 200));
         issue(r_op, r_a, r_b, 1'b1);
         wait_done(latency(r_op, r_b), "random", 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 128'(sb.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port i_start, input, 1, request to begin an operation.
REQ-004 SHALL have port i_md_op, input, 2, operation: 00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 reserved.
REQ-005 SHALL have port i_operand_a, input, 32, multiplicand / dividend (rs1_data).
REQ-006 SHALL have port i_operand_b, input, 32, multiplier / divisor (rs2_data).
REQ-007 SHALL have port i_flush, input, 1, abort the current operation.
REQ-008 SHALL have port i_alu_data, input, 32, result returned by the shared ALU.
REQ-009 SHALL have port o_alu_req, output, 1, claims the shared ALU for this cycle.
REQ-010 SHALL have port o_alu_a, output, 32, ALU operand A (op_a_sel = 0 path).
REQ-011 SHALL have port o_alu_b, output, 32, ALU operand B (op_b_sel = 0 path).
REQ-012 SHALL have port o_alu_op, output, 4, ALU selection: 0000 add, 0001 sub.
REQ-013 SHALL have port o_busy, output, 1, operation in progress; the pipeline stalls on it.
REQ-014 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port o_result, output, 32, final result.
REQ-016 SHALL have port o_err, output, 1, reserved op flag, valid with o_done.

Function
REQ-017 SHALL implement FSM states IDLE, ITER, DONE.
REQ-018 SHALL accept a start only in IDLE with i_start=1 and i_flush=0 (cycle T); i_start in any other state is ignored.
REQ-019 SHALL, for MUL/DIVU/REMU with a nonzero divisor, occupy ITER for exactly 32 cycles (T+1..T+32), then DONE at T+33.
REQ-020 SHALL, for divisor 0 or op 11, go from IDLE directly to DONE at T+1.
REQ-021 SHALL assert o_done only in DONE, for exactly one cycle, then return to IDLE.
REQ-022 SHALL drive o_busy=1 in ITER and DONE, and 0 in IDLE.
REQ-023 SHALL drive o_alu_req=1 only in ITER; otherwise o_alu_req=0 and o_alu_a/o_alu_b/o_alu_op=0.
REQ-024 SHALL perform each MUL iteration as follows:
- if the multiplier LSB is 1: o_alu_op=add, a=accumulator, b=multiplicand, and i_alu_data is written to the accumulator;
- then shift the multiplicand left 1 and the multiplier right 1, in local registers.
REQ-025 SHALL perform each DIV iteration as a restoring divide:
- partial = {rem[30:0], dividend MSB}, with o_alu_op=sub, a=partial, b=divisor;
- if partial >= divisor (local unsigned compare), rem = i_alu_data and the quotient bit = 1;
- otherwise rem = partial and the quotient bit = 0;
- shift the dividend left 1.
REQ-026 SHALL keep all arithmetic modulo 2^32; MUL discards the high product bits.
REQ-027 SHALL return DIVU by 0 as 0xFFFFFFFF and REMU by 0 as i_operand_a; op 11 returns 0 with o_err=1.
REQ-028 SHALL update o_result in DONE and hold it until the next DONE.
REQ-029 SHALL, on i_flush=1 in ITER or DONE, go to IDLE next cycle without o_done and with o_result unchanged.
REQ-030 SHALL give i_flush priority over i_start when both are high in IDLE.
REQ-031 SHALL latch operands at acceptance; operand input changes during ITER SHALL have no effect.

Reset
REQ-032 SHALL, on i_rst=1 at a rising edge (including mid-operation), enter IDLE with o_busy=0, o_done=0, o_err=0, o_result=0, o_alu_req=0, and all internal registers and the iteration counter cleared.
REQ-033 SHALL give i_rst priority over i_flush and i_start.

Structure
REQ-034 SHALL place the md_op encoding, the FSM state enum, and the constants ALU_ADD=4'b0000, ALU_SUB=4'b0001 and ITER_CNT=32 in shared package md_pkg.
REQ-035 SHALL be a single module with no sub-module; the ALU stays external and is shared through o_alu_req.

Verification
REQ-036 SHALL cover: MUL a=7, b=6, start at T -> o_busy T+1..T+33, o_done at T+33, o_result=42.
REQ-037 SHALL cover: DIVU 100/7 -> o_result=14 at T+33; REMU 100/7 -> o_result=2; MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE.
REQ-038 SHALL cover: DIVU 5/0 -> o_done at T+1, o_result=0xFFFFFFFF; REMU 5/0 -> 5; op 11 -> o_result=0, o_err=1.
REQ-039 SHALL cover: i_flush at T+10 of a MUL -> IDLE at T+11, no o_done, o_result keeps its prior value.
REQ-040 SHALL cover: i_start pulsed during ITER with new operands -> ignored, original result delivered.
REQ-041 SHALL cover: i_rst at T+20 of a DIVU -> all outputs 0 next cycle; a fresh start then completes normally.
